// File: rtl/uart_echo_engine_pkg.sv
// Shared definitions for the UART echo engine: transform mode encodings,
// FSM state encodings and the word transform applied at pop time.
package uart_echo_engine_pkg;

    // Widest word the engine supports; the transform works at this width
    // and callers cast the result down to their own DATA_W.
    localparam int MAX_W = 9;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ECHO = 2'b00;
    localparam mode_t MODE_INV  = 2'b01;
    localparam mode_t MODE_REV  = 2'b10;
    localparam mode_t MODE_DROP = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WAIT_BUSY = 2'd1;
    localparam state_t ST_WAIT_DONE = 2'd2;
    localparam state_t ST_GAP       = 2'd3;

    // Apply the run-time transform to the low 'width' bits of 'word'.
    // Bits at and above 'width' in the result are don't-care.
    function automatic logic [MAX_W-1:0] transform(
        input mode_t            mode,
        input logic [MAX_W-1:0] word,
        input int               width
    );
        logic [MAX_W-1:0] res;
        res = word;
        case (mode)
            MODE_INV: res = ~word;
            MODE_REV: begin
                res = '0;
                for (int i = 0; i < MAX_W; i++) begin
                    if (i < width) begin
                        res[width-1-i] = word[i];
                    end
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on o_rd_data
// whenever the FIFO is not empty. A push is accepted when not full, or
// when full but a pop happens in the same cycle.
module uart_echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_rd,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_rd && !w_empty;
    assign w_push  = i_wr && (!w_full || w_pop);

    // Storage write port.
    // NOTE: the data array has no reset; only pointers and count define
    // validity, so clearing the storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

// File: rtl/uart_echo_engine.sv
// Echo controller between a UART receiver and transmitter. Received words
// are buffered, transformed by the mode selected at pop time and replayed
// with a tx_val / busy handshake, with busy timeout, inter-frame gap,
// sticky overflow / error flags and wrapping traffic counters.
module uart_echo_engine
    import uart_echo_engine_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 256,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx_val,
    input  logic [DATA_W-1:0]      i_rx_data,
    input  logic                   i_busy,
    input  logic [1:0]             i_mode,
    input  logic                   i_ovf_clr,
    output logic                   o_tx_val,
    output logic [DATA_W-1:0]      o_tx_data,
    output logic [$clog2(DEPTH):0] o_fifo_count,
    output logic                   o_overflow,
    output logic                   o_tx_err,
    output logic [CNT_W-1:0]       o_rx_count,
    output logic [CNT_W-1:0]       o_tx_count
);

    // One timer serves both the busy timeout and the inter-frame gap.
    localparam int TMR_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic              r_tx_val;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_overflow;
    logic              r_tx_err;
    logic [CNT_W-1:0]  r_rx_count;
    logic [CNT_W-1:0]  r_tx_count;

    logic [DATA_W-1:0]      w_head;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_can_start;
    logic                   w_drop;
    logic                   w_send;
    logic                   w_pop;
    logic                   w_ovf_evt;
    logic                   w_busy_timeout;
    logic                   w_tx_done;
    logic [DATA_W-1:0]      w_xform;

    uart_echo_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (i_rx_val),
        .i_wr_data (i_rx_data),
        .i_rd      (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_fifo_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Discard mode drains the head regardless of busy; every other mode
    // waits for an idle transmitter before launching the word.
    assign w_can_start    = (r_state == ST_IDLE) && !w_empty;
    assign w_drop         = w_can_start && (i_mode == MODE_DROP);
    assign w_send         = w_can_start && (i_mode != MODE_DROP) && !i_busy;
    assign w_pop          = w_drop || w_send;
    assign w_ovf_evt      = i_rx_val && w_full && !w_pop;
    assign w_busy_timeout = (r_state == ST_WAIT_BUSY) && !i_busy &&
                            (r_timer == TMR_W'(BUSY_TIMEOUT - 1));
    assign w_tx_done      = (r_state == ST_WAIT_DONE) && !i_busy;
    assign w_xform        = DATA_W'(transform(i_mode, MAX_W'(w_head), DATA_W));

    // Transmit handshake FSM: launch, wait for busy to rise, wait for it to fall, then gap.
    // NOTE: all state here is updated with non-blocking assignments so every
    // branch sees the pre-edge values of r_state and r_timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_tx_val  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_val <= w_send;
            if (w_send) begin
                r_tx_data <= w_xform;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_send) begin
                        r_state <= ST_WAIT_BUSY;
                        r_timer <= '0;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (i_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (w_busy_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_busy) begin
                        r_timer <= '0;
                        r_state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_timer == TMR_W'(GAP_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags (a new event beats a same-cycle clear) and wrapping traffic counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_tx_err   <= 1'b0;
            r_rx_count <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_busy_timeout) begin
                r_tx_err <= 1'b1;
            end else if (i_ovf_clr) begin
                r_tx_err <= 1'b0;
            end
            if (i_rx_val && !w_ovf_evt) begin
                r_rx_count <= r_rx_count + CNT_W'(1);
            end
            if (w_tx_done) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
        end
    end

    assign o_tx_val     = r_tx_val;
    assign o_tx_data    = r_tx_data;
    assign o_fifo_count = w_fifo_count;
    assign o_overflow   = r_overflow;
    assign o_tx_err     = r_tx_err;
    assign o_rx_count   = r_rx_count;
    assign o_tx_count   = r_tx_count;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Scoreboard bench for uart_echo_engine: directed stimulus pushes the
// expected transmit words into a queue, a monitor pops and compares on
// every tx_val, and a behavioural transmitter drives busy.
module tb_uart_echo_engine;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int GAP     = 10;
    localparam int TMO     = 16;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_val = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic [1:0]        mode = 2'b00;
    logic              ovf_clr = 1'b0;
    logic              busy_hold = 1'b0;
    logic              busy_auto = 1'b0;
    logic              auto_en = 1'b1;
    logic              model_active = 1'b0;
    logic              busy;

    logic              tx_val;
    logic [DATA_W-1:0] tx_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic              overflow;
    logic              tx_err;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  tx_count;

    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    logic [DATA_W-1:0] exp_q[$];
    int               tx_cyc_q[$];
    int               fall_q[$];

    assign busy = busy_hold | busy_auto;

    uart_echo_engine #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (TMO),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_val     (rx_val),
        .i_rx_data    (rx_data),
        .i_busy       (busy),
        .i_mode       (mode),
        .i_ovf_clr    (ovf_clr),
        .o_tx_val     (tx_val),
        .o_tx_data    (tx_data),
        .o_fifo_count (fifo_count),
        .o_overflow   (overflow),
        .o_tx_err     (tx_err),
        .o_rx_count   (rx_count),
        .o_tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time latencies and gaps.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every transmit strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && tx_val) begin
            tx_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got tx_data 0x%0h, expected no transmission (cycle %0d)", tx_data, cyc);
            end else begin
                check("tx_data", tx_data, exp_q.pop_front());
            end
        end
    end

    // Behavioural transmitter: busy rises 3 cycles after tx_val, falls 100 cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_val && auto_en) begin
                model_active = 1'b1;
                repeat (3) @(negedge clk);
                busy_auto = 1'b1;
                repeat (100) @(negedge clk);
                busy_auto = 1'b0;
                fall_q.push_back(cyc);
                model_active = 1'b0;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [DATA_W-1:0] d);
        rx_val  = 1'b1;
        rx_data = d;
        @(negedge clk);
        rx_val  = 1'b0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    // Wait until all expected words are sent and the transmitter is idle.
    task automatic drain();
        int  stable = 0;
        bit  done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !model_active && !busy) stable++;
            else stable = 0;
            if (stable >= 5) done = 1'b1;
        end
        repeat (GAP + 4) @(negedge clk);
        check("drain_done", 32'(done), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_val"},     32'(tx_val),     0);
        check({tag, "_tx_data"},    32'(tx_data),    0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 0);
        check({tag, "_overflow"},   32'(overflow),   0);
        check({tag, "_tx_err"},     32'(tx_err),     0);
        check({tag, "_rx_count"},   32'(rx_count),   0);
        check({tag, "_tx_count"},   32'(tx_count),   0);
    endtask

    initial begin
        int n0;
        int err_cyc;
        bit seen;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        // Echo with latency: fifo_count=1 in k+1, tx_val and fifo_count=0 in k+2
        mode = 2'b00;
        exp_q.push_back(8'hAC);
        send(8'hAC);
        check("lat_cnt_k1",   32'(fifo_count), 1);
        check("lat_txval_k1", 32'(tx_val),     0);
        @(negedge clk);
        check("lat_txval_k2", 32'(tx_val),     1);
        check("lat_cnt_k2",   32'(fifo_count), 0);
        drain();
        check("echo_rx_count", 32'(rx_count), 1);
        check("echo_tx_count", 32'(tx_count), 1);

        // Transforms
        mode = 2'b01;
        exp_q.push_back(8'h53);
        send(8'hAC);
        drain();
        mode = 2'b10;
        exp_q.push_back(8'h35);
        send(8'hAC);
        drain();
        check("xf_tx_count", 32'(tx_count), 3);
        check("xf_rx_count", 32'(rx_count), 3);
        mode = 2'b11;
        send(8'hAC);
        repeat (4) @(negedge clk);
        check("drop_fifo_count", 32'(fifo_count), 0);
        check("drop_tx_count",   32'(tx_count),   3);
        check("drop_rx_count",   32'(rx_count),   4);
        mode = 2'b00;
        repeat (2) @(negedge clk);

        // Overflow with busy held
        busy_hold = 1'b1;
        for (int d = 1; d <= 5; d++) send(DATA_W'(d));
        check("ovf_fifo_count", 32'(fifo_count), 4);
        check("ovf_flag",       32'(overflow),   1);
        check("ovf_rx_count",   32'(rx_count),   8);
        for (int d = 1; d <= 4; d++) exp_q.push_back(DATA_W'(d));
        busy_hold = 1'b0;
        drain();
        check("ovf_tx_count",  32'(tx_count), 7);
        check("ovf_sticky",    32'(overflow), 1);
        pulse_clr();
        check("ovf_cleared",   32'(overflow), 0);

        // Full FIFO with simultaneous push and pop
        busy_hold = 1'b1;
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back(8'hA1 + DATA_W'(d));
            send(8'hA1 + DATA_W'(d));
        end
        check("full_fifo_count", 32'(fifo_count), 4);
        exp_q.push_back(8'h77);
        busy_hold = 1'b0;
        send(8'h77);
        check("pp_overflow",   32'(overflow),   0);
        check("pp_fifo_count", 32'(fifo_count), 4);
        check("pp_rx_count",   32'(rx_count),   13);
        drain();
        check("pp_tx_count",   32'(tx_count),   12);

        // Busy timeout
        auto_en = 1'b0;
        n0 = tx_cyc_q.size();
        exp_q.push_back(8'h3C);
        send(8'h3C);
        seen = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (tx_err) begin
                seen = 1'b1;
                err_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("tmo_seen", 32'(seen), 1);
        check("tmo_tx_seen", 32'(tx_cyc_q.size()), 32'(n0 + 1));
        if (tx_cyc_q.size() > n0) check("tmo_delay", 32'(err_cyc - tx_cyc_q[n0]), TMO);
        repeat (3) @(negedge clk);
        check("tmo_tx_count", 32'(tx_count), 12);
        auto_en = 1'b1;
        exp_q.push_back(8'h4B);
        send(8'h4B);
        drain();
        check("after_tmo_tx_count", 32'(tx_count), 13);
        check("tmo_sticky",         32'(tx_err),   1);
        pulse_clr();
        check("tmo_cleared",        32'(tx_err),   0);

        // Reset during WAIT_DONE with 3 words queued
        exp_q.push_back(8'h11);
        send(8'h11);
        repeat (10) @(negedge clk);
        send(8'h21);
        send(8'h22);
        send(8'h23);
        check("pre_rst_fifo_count", 32'(fifo_count), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        for (int i = 0; i < 200 && model_active; i++) @(negedge clk);
        repeat (3) @(negedge clk);

        // Back-to-back words with inter-frame gap
        n0 = tx_cyc_q.size();
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5B);
        send(8'h5A);
        send(8'h5B);
        drain();
        check("gap_tx_seen", 32'(tx_cyc_q.size()), 32'(n0 + 2));
        if (tx_cyc_q.size() >= n0 + 2 && fall_q.size() >= 2)
            check("gap_spacing", 32'(tx_cyc_q[n0+1] - fall_q[fall_q.size()-2]), GAP + 2);
        check("gap_tx_count", 32'(tx_count), 2);
        check("gap_rx_count", 32'(rx_count), 2);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
